dht11_uart_reporter: RTL and testbench
======================================

DHT11_UART_REPORTER -- requirements
Module: dht11_uart_reporter

Interface
REQ-001 Parameter CLK_FREQ, default 50000000: clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200: UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 sample_valid  input  1  one-cycle strobe; the four reading bytes are valid in the same cycle.
REQ-006 humidity  input  8  humidity integer part, unsigned.
REQ-007 humidity_fraction  input  8  humidity fractional digit.
REQ-008 temp  input  8  temperature integer part, unsigned.
REQ-009 temp_fraction  input  8  temperature fractional digit.
REQ-010 uart_tx  output  1  serial line, idle high.
REQ-011 busy  output  1  high while a sample is held or being transmitted.
REQ-012 dropped  output  1  one-cycle pulse when a sample is rejected.
REQ-013 frame_count  output  16  number of completed messages.

Function
REQ-014 Acceptance: a sample is accepted when sample_valid=1 and busy=0; all four bytes are latched in that cycle, and busy=1 from the next cycle.
REQ-015 Rejection: sample_valid=1 with busy=1 leaves the latched data unchanged; dropped=1 in the next cycle for exactly one cycle.
REQ-016 Message: 17 ASCII bytes "H=ddd.f T=ddd.f" followed by CR (0x0D) and LF (0x0A), humidity first.
REQ-017 ddd: integer byte in decimal, 3 digits, zero-padded (0 -> "000", 255 -> "255").
REQ-018 f: fraction byte as a single digit ('0'+value); any value greater than 9 is sent as '9'.
REQ-019 Conversion: binary-to-BCD by either combinational or iterative logic; the start bit of the first byte begins no later than 16 clk cycles after acceptance.
REQ-020 Framing: 8N1, LSB first.
REQ-021 Bit timing: start, each of the 8 data bits, and stop each last exactly CLKS_PER_BIT cycles.
REQ-022 Byte spacing: the next start bit follows the previous stop bit directly, with no extra idle cycles.
REQ-023 FSM states: IDLE, CONVERT, LOAD, START, DATA, STOP.
REQ-024 FSM transitions:
- IDLE -> CONVERT on acceptance.
- CONVERT -> LOAD when the digits are ready.
- LOAD -> START once the character is selected.
- START -> DATA after one bit time.
- DATA -> STOP after 8 bits.
- STOP -> LOAD if bytes remain; STOP -> IDLE after the LF stop bit.
REQ-025 Completion: busy falls in the cycle after the last LF stop-bit cycle, and frame_count increments (wrapping 0xFFFF -> 0x0000) in that same cycle.
REQ-026 Sample in the first cycle with busy=0 is accepted; acceptance and the busy fall are never lost.
REQ-027 uart_tx is high in IDLE and CONVERT, and is registered with no glitches.
REQ-028 Input bytes that change while busy have no effect on the message in flight.

Reset
REQ-029 rst=1 immediately forces uart_tx=1, busy=0, dropped=0, frame_count=0, and state IDLE.
REQ-030 Reset mid-message aborts the frame; the line stays high and no partial byte resumes after release.
REQ-031 The first sample_valid after rst falls is accepted normally.

Verification (CLK_FREQ=1000, BAUD=100 -> 10 clk/bit, 1700 cycles/message)
REQ-032 Nominal:
- Stimulus: humidity=55, humidity_fraction=0, temp=23, temp_fraction=4, one strobe.
- Required: a UART monitor decodes "H=055.0 T=023.4\r\n", every bit lasts exactly 10 cycles, busy falls after the LF, and frame_count=1.
REQ-033 Boundaries:
- Stimulus: humidity=0, humidity_fraction=12, temp=255, temp_fraction=9.
- Required: the monitor decodes "H=000.9 T=255.9\r\n".
REQ-034 Drop:
- Stimulus: a second strobe 500 cycles into a message.
- Required: dropped pulses for exactly 1 cycle and the first message is unchanged.
- Required: a strobe in the first cycle with busy=0 yields a second full message with no gap error.
REQ-035 Reset:
- Stimulus: rst asserted during the DATA bits of byte 5.
- Required: uart_tx=1 and busy=0 in the same cycle.
- Required: after release, a new strobe produces a complete correct message and frame_count=1.
REQ-036 Wrap: preload or run frame_count to 0xFFFF, then one message -> frame_count=0x0000.
REQ-037 Input isolation: randomize all input bytes every cycle while busy -> the transmitted message matches the bytes latched at acceptance.

Source files
------------

// File: rtl/dht11_uart_reporter.sv
// =============================================================================
// dht11_uart_reporter : formats a DHT11 reading as "H=ddd.f T=ddd.f\r\n" on 8N1 UART
// Revision: 1.0
// =============================================================================
`default_nettype none

module dht11_uart_reporter #(
  parameter int          CLK_FREQ         = 50000000,
  parameter int          BAUD             = 115200,
  parameter logic [15:0] FRAME_COUNT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [7:0]  humidity,
  input  logic [7:0]  humidity_fraction,
  input  logic [7:0]  temp,
  input  logic [7:0]  temp_fraction,
  output logic        uart_tx,
  output logic        busy,
  output logic        dropped,
  output logic [15:0] frame_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int STOP_EARLY_I = (CLKS_PER_BIT >= 2) ? CLKS_PER_BIT - 2 : 0;
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_EARLY = CNT_W'(STOP_EARLY_I);
  localparam logic [4:0]       LAST_BYTE  = 5'd16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    LOAD    = 3'd2,
    START   = 3'd3,
    DATA    = 3'd4,
    STOP    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        hum_q, hum_d, hum_frac_q, hum_frac_d;
  logic [7:0]        tmp_q, tmp_d, tmp_frac_q, tmp_frac_d;
  logic [11:0]       hbcd_q, hbcd_d, tbcd_q, tbcd_d;
  logic [3:0]        hf_q, hf_d, tf_q, tf_d;
  logic [4:0]        byte_idx_q, byte_idx_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic              tx_q, tx_d, busy_q, busy_d, dropped_q, dropped_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [7:0]        ch;

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    logic [11:0] b;
    b = 12'd0;
    for (int i = 7; i >= 0; i--) begin
      if (b[3:0] >= 4'd5) b[3:0] = b[3:0] + 4'd3;
      if (b[7:4] >= 4'd5) b[7:4] = b[7:4] + 4'd3;
      b = {b[10:0], v[i]};
    end
    return b;
  endfunction

  always_comb begin
    ch = 8'h0A;
    case (byte_idx_q)
      5'd0:    ch = 8'h48;
      5'd1:    ch = 8'h3D;
      5'd2:    ch = {4'h3, hbcd_q[11:8]};
      5'd3:    ch = {4'h3, hbcd_q[7:4]};
      5'd4:    ch = {4'h3, hbcd_q[3:0]};
      5'd5:    ch = 8'h2E;
      5'd6:    ch = {4'h3, hf_q};
      5'd7:    ch = 8'h20;
      5'd8:    ch = 8'h54;
      5'd9:    ch = 8'h3D;
      5'd10:   ch = {4'h3, tbcd_q[11:8]};
      5'd11:   ch = {4'h3, tbcd_q[7:4]};
      5'd12:   ch = {4'h3, tbcd_q[3:0]};
      5'd13:   ch = 8'h2E;
      5'd14:   ch = {4'h3, tf_q};
      5'd15:   ch = 8'h0D;
      default: ch = 8'h0A;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    hum_d         = hum_q;
    hum_frac_d    = hum_frac_q;
    tmp_d         = tmp_q;
    tmp_frac_d    = tmp_frac_q;
    hbcd_d        = hbcd_q;
    tbcd_d        = tbcd_q;
    hf_d          = hf_q;
    tf_d          = tf_q;
    byte_idx_d    = byte_idx_q;
    bit_idx_d     = bit_idx_q;
    cnt_d         = cnt_q + 1'b1;
    sh_d          = sh_q;
    tx_d          = tx_q;
    frame_count_d = frame_count_q;
    dropped_d     = sample_valid & busy_q;

    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (sample_valid) begin
          hum_d      = humidity;
          hum_frac_d = humidity_fraction;
          tmp_d      = temp;
          tmp_frac_d = temp_fraction;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        hbcd_d     = to_bcd(hum_q);
        tbcd_d     = to_bcd(tmp_q);
        hf_d       = (hum_frac_q > 8'd9) ? 4'd9 : hum_frac_q[3:0];
        tf_d       = (tmp_frac_q > 8'd9) ? 4'd9 : tmp_frac_q[3:0];
        byte_idx_d = 5'd0;
        state_d    = LOAD;
      end
      LOAD: begin
        sh_d    = ch;
        tx_d    = 1'b0;
        cnt_d   = '0;
        state_d = START;
      end
      START: begin
        if (cnt_q == BIT_LAST) begin
          tx_d      = sh_q[0];
          sh_d      = {1'b0, sh_q[7:1]};
          bit_idx_d = 3'd0;
          cnt_d     = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d      = sh_q[0];
            sh_d      = {1'b0, sh_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        // Leave one cycle early for non-final bytes: the LOAD cycle completes the stop bit.
        if (byte_idx_q == LAST_BYTE) begin
          if (cnt_q == BIT_LAST) begin
            frame_count_d = frame_count_q + 16'd1;
            state_d       = IDLE;
          end
        end else if (cnt_q == STOP_EARLY) begin
          byte_idx_d = byte_idx_q + 5'd1;
          state_d    = LOAD;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      hum_q         <= '0;
      hum_frac_q    <= '0;
      tmp_q         <= '0;
      tmp_frac_q    <= '0;
      hbcd_q        <= '0;
      tbcd_q        <= '0;
      hf_q          <= '0;
      tf_q          <= '0;
      byte_idx_q    <= '0;
      bit_idx_q     <= '0;
      cnt_q         <= '0;
      sh_q          <= '0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      dropped_q     <= 1'b0;
      frame_count_q <= FRAME_COUNT_INIT;
    end else begin
      state_q       <= state_d;
      hum_q         <= hum_d;
      hum_frac_q    <= hum_frac_d;
      tmp_q         <= tmp_d;
      tmp_frac_q    <= tmp_frac_d;
      hbcd_q        <= hbcd_d;
      tbcd_q        <= tbcd_d;
      hf_q          <= hf_d;
      tf_q          <= tf_d;
      byte_idx_q    <= byte_idx_d;
      bit_idx_q     <= bit_idx_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      dropped_q     <= dropped_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign uart_tx     = tx_q;
  assign busy        = busy_q;
  assign dropped     = dropped_q;
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_dht11_uart_reporter.sv
// =============================================================================
// tb_dht11_uart_reporter : vector table, random messages, drop, reset and wrap
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_dht11_uart_reporter;

  localparam int CPB     = 10;
  localparam int BYTE_CY = 10 * CPB;
  localparam int MSG_CYC = 17 * BYTE_CY;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic        sample_valid_w = 1'b0;
  logic [7:0]  humidity = '0, humidity_fraction = '0, temp = '0, temp_fraction = '0;
  logic        uart_tx, busy, dropped;
  logic [15:0] frame_count;
  logic        uart_tx_w, busy_w, dropped_w;
  logic [15:0] frame_count_w;

  int passed = 0;
  int total  = 0;
  int nmsg   = 0;

  always #5 clk = ~clk;

  dht11_uart_reporter #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .humidity(humidity), .humidity_fraction(humidity_fraction),
    .temp(temp), .temp_fraction(temp_fraction),
    .uart_tx(uart_tx), .busy(busy), .dropped(dropped), .frame_count(frame_count)
  );

  dht11_uart_reporter #(.CLK_FREQ(1000), .BAUD(100), .FRAME_COUNT_INIT(16'hFFFF)) dut_w (
    .clk(clk), .rst(rst), .sample_valid(sample_valid_w),
    .humidity(humidity), .humidity_fraction(humidity_fraction),
    .temp(temp), .temp_fraction(temp_fraction),
    .uart_tx(uart_tx_w), .busy(busy_w), .dropped(dropped_w), .frame_count(frame_count_w)
  );

  typedef struct {
    logic [7:0] h, hf, t, tf;
    string      exp;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic string printable(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D) r = {r, "<CR>"};
      else if (s[i] == 8'h0A) r = {r, "<LF>"};
      else r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  task automatic chk_str(input string name, input string got, input string exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", name, printable(got), printable(exp));
  endtask

  // Reference: the message text straight from the reading, fractions clamped to one digit.
  function automatic string model(input logic [7:0] h, hf, t, tf);
    int fh = (hf > 9) ? 9 : int'(hf);
    int ft = (tf > 9) ? 9 : int'(tf);
    return $sformatf("H=%03d.%0d T=%03d.%0d\015\012", h, fh, t, ft);
  endfunction

  // Expected line level i cycles after the first start bit: start, 8 data LSB first, stop.
  function automatic logic exp_bit(input string s, input int i);
    int b  = i / BYTE_CY;
    int bp = (i % BYTE_CY) / CPB;
    logic [7:0] c;
    c = s[b];
    if (bp == 0) return 1'b0;
    if (bp == 9) return 1'b1;
    return c[bp-1];
  endfunction

  task automatic randomize_bytes();
    humidity          = 8'($urandom);
    humidity_fraction = 8'($urandom);
    temp              = 8'($urandom);
    temp_fraction     = 8'($urandom);
  endtask

  // Called at a negedge with the DUT idle; strobes one sample and checks the whole frame.
  task automatic run_msg(input logic [7:0] h, hf, t, tf, input string exp, input string name,
                         input bit rnd, input int drop_at, input logic [15:0] exp_count);
    string got = "";
    int lat = 1, wave_err = 0, busy_err = 0, drop_cnt = 0, drop_pos = -1;
    logic [7:0] ch = '0;
    humidity = h; humidity_fraction = hf; temp = t; temp_fraction = tf;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk({name, " accept busy"}, 64'(busy), 64'd1);
    while (uart_tx !== 1'b0 && lat <= 20) begin
      if (rnd) randomize_bytes();
      @(negedge clk);
      lat++;
    end
    chk({name, " start latency<=16"}, 64'(lat - 1 <= 16), 64'd1);
    if (lat > 20) return;
    for (int i = 0; i < MSG_CYC; i++) begin
      if (uart_tx !== exp_bit(exp, i)) wave_err++;
      if (busy !== 1'b1) busy_err++;
      if (dropped === 1'b1) begin drop_cnt++; drop_pos = i; end
      if ((i % CPB) == CPB / 2) begin
        if ((i % BYTE_CY) / CPB inside {[1:8]}) ch[(i % BYTE_CY) / CPB - 1] = uart_tx;
        if ((i % BYTE_CY) / CPB == 9) got = $sformatf("%s%c", got, ch);
      end
      if (rnd) randomize_bytes();
      sample_valid = (i == drop_at);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk_str({name, " decoded"}, got, exp);
    chk({name, " waveform cycle errors"}, 64'(wave_err), 64'd0);
    chk({name, " busy gaps"}, 64'(busy_err), 64'd0);
    chk({name, " busy falls after LF"}, 64'(busy), 64'd0);
    chk({name, " line idle"}, 64'(uart_tx), 64'd1);
    chk({name, " frame_count"}, 64'(frame_count), 64'(exp_count));
    chk({name, " dropped pulses"}, 64'(drop_cnt), (drop_at >= 0) ? 64'd1 : 64'd0);
    if (drop_at >= 0) chk({name, " dropped position"}, 64'(drop_pos), 64'(drop_at + 1));
  endtask

  initial begin
    int wait_cy, low_cy, busy_cy;
    logic [7:0] rh, rhf, rt, rtf;

    tbl[0] = '{h: 8'd55,  hf: 8'd0,  t: 8'd23,  tf: 8'd4,  exp: "H=055.0 T=023.4\015\012"};
    tbl[1] = '{h: 8'd0,   hf: 8'd12, t: 8'd255, tf: 8'd9,  exp: "H=000.9 T=255.9\015\012"};
    tbl[2] = '{h: 8'd100, hf: 8'd5,  t: 8'd99,  tf: 8'd10, exp: "H=100.5 T=099.9\015\012"};
    tbl[3] = '{h: 8'd9,   hf: 8'd9,  t: 8'd199, tf: 8'd0,  exp: "H=009.9 T=199.0\015\012"};

    repeat (3) @(negedge clk);
    chk("reset uart_tx", 64'(uart_tx), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset dropped", 64'(dropped), 64'd0);
    chk("reset frame_count", 64'(frame_count), 64'd0);
    chk("reset preload frame_count", 64'(frame_count_w), 64'hFFFF);
    rst = 1'b0;
    @(negedge clk);

    // Counter wrap on the preloaded instance.
    humidity = 8'd1; humidity_fraction = 8'd2; temp = 8'd3; temp_fraction = 8'd4;
    sample_valid_w = 1'b1;
    @(negedge clk);
    sample_valid_w = 1'b0;
    chk("wrap busy", 64'(busy_w), 64'd1);
    wait_cy = 0;
    while (busy_w === 1'b1 && wait_cy < 2000) begin @(negedge clk); wait_cy++; end
    chk("wrap completed in time", 64'(wait_cy < 2000), 64'd1);
    chk("wrap frame_count", 64'(frame_count_w), 64'h0000);

    // Vector table; each strobe lands in the first idle cycle of the previous message.
    for (int k = 0; k < 4; k++) begin
      nmsg++;
      run_msg(tbl[k].h, tbl[k].hf, tbl[k].t, tbl[k].tf, tbl[k].exp,
              $sformatf("vec%0d", k), 1'b0, -1, 16'(nmsg));
    end

    // Rejected strobe 500 cycles into a message.
    rh = 8'($urandom); rhf = 8'($urandom); rt = 8'($urandom); rtf = 8'($urandom);
    nmsg++;
    run_msg(rh, rhf, rt, rtf, model(rh, rhf, rt, rtf), "drop", 1'b0, 500, 16'(nmsg));

    // Input isolation with random readings.
    for (int k = 0; k < 3; k++) begin
      rh = 8'($urandom); rhf = 8'($urandom_range(0, 15)); rt = 8'($urandom); rtf = 8'($urandom);
      nmsg++;
      run_msg(rh, rhf, rt, rtf, model(rh, rhf, rt, rtf), $sformatf("rand%0d", k),
              1'b1, -1, 16'(nmsg));
    end

    // Reset during the data bits of byte 5.
    humidity = 8'd77; humidity_fraction = 8'd1; temp = 8'd88; temp_fraction = 8'd2;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_cy = 0;
    while (uart_tx !== 1'b0 && wait_cy < 20) begin @(negedge clk); wait_cy++; end
    chk("reset test start seen", 64'(wait_cy < 20), 64'd1);
    repeat (5 * BYTE_CY + 3 * CPB) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async reset uart_tx", 64'(uart_tx), 64'd1);
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset frame_count", 64'(frame_count), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    low_cy = 0; busy_cy = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) low_cy++;
      if (busy !== 1'b0) busy_cy++;
    end
    chk("post-reset line low cycles", 64'(low_cy), 64'd0);
    chk("post-reset busy cycles", 64'(busy_cy), 64'd0);
    run_msg(tbl[0].h, tbl[0].hf, tbl[0].t, tbl[0].tf, tbl[0].exp, "after reset",
            1'b0, -1, 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
